// File: rtl/gpio_irq.sv
// gpio_irq: memory-mapped GPIO block with per-pin direction, output set/clear/toggle,
// synchronised inputs and edge-triggered interrupts.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   addr       word register index (0..15)
//   we         write strobe, one write per asserted cycle
//   wdata      write data, bits above WIDTH ignored
//   rdata      combinational read data for addr, bits above WIDTH read 0
//   gpio_pins  bidirectional pins, driven from OUT where DIR=1
//   irq        level interrupt: OR of pending status bits that are enabled
//
// Register map: 0 DIR, 1 OUT, 2 IN (ro), 3 OUT_SET, 4 OUT_CLR, 5 OUT_TGL (wo, read 0),
// 6 IRQ_EN, 7 IRQ_RISE, 8 IRQ_FALL, 9 IRQ_STAT (write-1-to-clear), 10-15 reserved.
module gpio_irq #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    inout  wire  [WIDTH-1:0] gpio_pins,
    output logic             irq
);

    localparam logic [3:0] A_DIR      = 4'd0;
    localparam logic [3:0] A_OUT      = 4'd1;
    localparam logic [3:0] A_IN       = 4'd2;
    localparam logic [3:0] A_OUT_SET  = 4'd3;
    localparam logic [3:0] A_OUT_CLR  = 4'd4;
    localparam logic [3:0] A_OUT_TGL  = 4'd5;
    localparam logic [3:0] A_IRQ_EN   = 4'd6;
    localparam logic [3:0] A_IRQ_RISE = 4'd7;
    localparam logic [3:0] A_IRQ_FALL = 4'd8;
    localparam logic [3:0] A_IRQ_STAT = 4'd9;

    logic [WIDTH-1:0] dir_q,      dir_d;
    logic [WIDTH-1:0] out_q,      out_d;
    logic [WIDTH-1:0] irq_en_q,   irq_en_d;
    logic [WIDTH-1:0] irq_rise_q, irq_rise_d;
    logic [WIDTH-1:0] irq_fall_q, irq_fall_d;
    logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
    logic [WIDTH-1:0] prev_q,     prev_d;
    logic [WIDTH-1:0] evt_q,      evt_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] stat_clr_w;

    assign wdata_w = wdata[WIDTH-1:0];
    assign in_w    = sync_q[SYNC_STAGES-1];
    assign rise_w  = in_w & ~prev_q;
    assign fall_w  = ~in_w & prev_q;

    // Each pin is released to high-impedance unless configured as an output.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        dir_d      = dir_q;
        out_d      = out_q;
        irq_en_d   = irq_en_q;
        irq_rise_d = irq_rise_q;
        irq_fall_d = irq_fall_q;
        stat_clr_w = '0;

        sync_d[0] = gpio_pins;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = in_w;

        // Masked edge events are registered once before capture, which places the
        // IRQ_STAT update SYNC_STAGES+1 edges after the pin is first sampled.
        evt_d = (rise_w & irq_rise_q) | (fall_w & irq_fall_q);

        if (we) begin
            case (addr)
                A_DIR:      dir_d      = wdata_w;
                A_OUT:      out_d      = wdata_w;
                A_OUT_SET:  out_d      = out_q | wdata_w;
                A_OUT_CLR:  out_d      = out_q & ~wdata_w;
                A_OUT_TGL:  out_d      = out_q ^ wdata_w;
                A_IRQ_EN:   irq_en_d   = wdata_w;
                A_IRQ_RISE: irq_rise_d = wdata_w;
                A_IRQ_FALL: irq_fall_d = wdata_w;
                A_IRQ_STAT: stat_clr_w = wdata_w;
                default:    ;
            endcase
        end

        // Clear is applied before set so a new edge wins over a same-cycle W1C.
        irq_stat_d = (irq_stat_q & ~stat_clr_w) | evt_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order.
        if (rst) begin
            dir_q      <= '0;
            out_q      <= '0;
            irq_en_q   <= '0;
            irq_rise_q <= '0;
            irq_fall_q <= '0;
            irq_stat_q <= '0;
            prev_q     <= '0;
            evt_q      <= '0;
            sync_q     <= '0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            irq_en_q   <= irq_en_d;
            irq_rise_q <= irq_rise_d;
            irq_fall_q <= irq_fall_d;
            irq_stat_q <= irq_stat_d;
            prev_q     <= prev_d;
            evt_q      <= evt_d;
            sync_q     <= sync_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_DIR:      rdata[WIDTH-1:0] = dir_q;
            A_OUT:      rdata[WIDTH-1:0] = out_q;
            A_IN:       rdata[WIDTH-1:0] = in_w;
            A_IRQ_EN:   rdata[WIDTH-1:0] = irq_en_q;
            A_IRQ_RISE: rdata[WIDTH-1:0] = irq_rise_q;
            A_IRQ_FALL: rdata[WIDTH-1:0] = irq_fall_q;
            A_IRQ_STAT: rdata[WIDTH-1:0] = irq_stat_q;
            default:    ;
        endcase
    end

    assign irq = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: self-checking bench for gpio_irq with WIDTH=8, SYNC_STAGES=2.
// Directed register-map vectors, hand-written interrupt timing sequences, then a
// randomised run compared against a pin-history reference model.
module tb_gpio_irq;

    localparam int W = 8;
    localparam int S = 2;
    localparam int HIST = 4096;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    wire  [W-1:0] pins;
    logic        irq;

    logic [W-1:0] ext_drv;
    logic [W-1:0] ext_en;

    int n_checks = 0;
    int n_errors = 0;

    gpio_irq #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .gpio_pins (pins),
        .irq       (irq)
    );

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign pins[i] = ext_en[i] ? ext_drv[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Directed register-map vectors: optional write, then a read-back and pin check.
    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp_rdata;
        logic        chk_pins;
        logic [7:0]  exp_pins;
    } vec_t;

    vec_t vecs[16];

    // Reference model state for the randomised run.
    logic [W-1:0] m_dir, m_out, m_en, m_rise, m_fall, m_stat;
    logic [W-1:0] samp [HIST];
    logic [W-1:0] hr   [HIST];
    logic [W-1:0] hf   [HIST];
    int           n_edge;
    int           last_rst;

    // Pin value the synchroniser captured at edge j; nothing captured at or before a reset edge.
    function automatic logic [W-1:0] smp(input int j);
        if (j <= last_rst) return '0;
        return samp[j];
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [W-1:0] v;
        case (a)
            4'd0:    v = m_dir;
            4'd1:    v = m_out;
            4'd2:    v = smp(n_edge - S + 1);
            4'd6:    v = m_en;
            4'd7:    v = m_rise;
            4'd8:    v = m_fall;
            4'd9:    v = m_stat;
            default: v = '0;
        endcase
        return {{(32-W){1'b0}}, v};
    endfunction

    initial begin
        rst = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        ext_drv = '0; ext_en = '0;

        // ---------------- reset state ----------------
        @(negedge clk);
        do_reset();
        rd_chk("reset_dir", 4'd0, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        ext_en = 8'hFF; ext_drv = 8'h5A;
        #1;
        check("reset_pins_hiz", {24'b0, pins}, 32'h5A);
        ext_en = 8'h00;

        // ---------------- register map table ----------------
        vecs[0]  = '{1'b1, 4'd0,  32'h0000_00FF, 4'd0,  32'h0000_00FF, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 4'd1,  32'h0000_00A5, 4'd1,  32'h0000_00A5, 1'b1, 8'hA5};
        vecs[2]  = '{1'b1, 4'd3,  32'h0000_000A, 4'd1,  32'h0000_00AF, 1'b1, 8'hAF};
        vecs[3]  = '{1'b1, 4'd4,  32'h0000_0081, 4'd1,  32'h0000_002E, 1'b1, 8'h2E};
        vecs[4]  = '{1'b1, 4'd5,  32'h0000_00FF, 4'd1,  32'h0000_00D1, 1'b1, 8'hD1};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,         4'd3,  32'h0,         1'b1, 8'hD1};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,         4'd4,  32'h0,         1'b1, 8'hD1};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,         4'd5,  32'h0,         1'b1, 8'hD1};
        vecs[8]  = '{1'b1, 4'd0,  32'hFFFF_FFFF, 4'd0,  32'h0000_00FF, 1'b1, 8'hD1};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,         4'd12, 32'h0,         1'b1, 8'hD1};
        vecs[10] = '{1'b1, 4'd12, 32'hFFFF_FFFF, 4'd12, 32'h0,         1'b1, 8'hD1};
        vecs[11] = '{1'b1, 4'd6,  32'hFFFF_FF3C, 4'd6,  32'h0000_003C, 1'b1, 8'hD1};
        vecs[12] = '{1'b1, 4'd7,  32'h0000_0012, 4'd7,  32'h0000_0012, 1'b1, 8'hD1};
        vecs[13] = '{1'b1, 4'd8,  32'h0000_0040, 4'd8,  32'h0000_0040, 1'b1, 8'hD1};
        vecs[14] = '{1'b0, 4'd0,  32'h0,         4'd2,  32'h0000_00D1, 1'b1, 8'hD1};
        vecs[15] = '{1'b0, 4'd0,  32'h0,         4'd9,  32'h0,         1'b1, 8'hD1};

        for (int i = 0; i < 16; i++) begin
            we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            tick();
            we = 1'b0;
            rd_chk($sformatf("vec%0d_rdata", i), vecs[i].raddr, vecs[i].exp_rdata);
            if (vecs[i].chk_pins)
                check($sformatf("vec%0d_pins", i), {24'b0, pins}, {24'b0, vecs[i].exp_pins});
        end

        // ---------------- rise latency: IN after k+1, IRQ_STAT/irq after k+3 ----------------
        do_reset();
        ext_en = 8'hFF; ext_drv = 8'h00;
        repeat (4) tick();
        wr(4'd7, 32'h08);
        wr(4'd6, 32'h08);
        ext_drv = 8'h08;              // sampled at edge k
        tick();                       // edge k
        rd_chk("lat_in_k", 4'd2, 32'h00);
        tick();                       // edge k+1
        rd_chk("lat_in_k1", 4'd2, 32'h08);
        tick();                       // edge k+2
        rd_chk("lat_stat_k2", 4'd9, 32'h00);
        check("lat_irq_k2", {31'b0, irq}, 32'h0);
        tick();                       // edge k+3
        rd_chk("lat_stat_k3", 4'd9, 32'h08);
        check("lat_irq_k3", {31'b0, irq}, 32'h1);

        // ---------------- W1C, and set winning over a same-edge clear ----------------
        wr(4'd9, 32'h08);
        rd_chk("w1c_stat", 4'd9, 32'h00);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        ext_drv = 8'h00;
        repeat (5) tick();
        rd_chk("fall_masked", 4'd9, 32'h00);
        ext_drv = 8'h08;              // sampled at edge k
        repeat (3) tick();            // edges k..k+2
        wr(4'd9, 32'h08);             // W1C lands on edge k+3
        rd_chk("set_wins_stat", 4'd9, 32'h08);
        check("set_wins_irq", {31'b0, irq}, 32'h1);

        // ---------------- fall capture independent of IRQ_EN ----------------
        do_reset();
        ext_en = 8'hFF; ext_drv = 8'h01;
        repeat (6) tick();
        wr(4'd8, 32'h01);
        ext_drv = 8'h00;
        repeat (5) tick();
        rd_chk("fall_stat", 4'd9, 32'h01);
        check("fall_irq_gated", {31'b0, irq}, 32'h0);
        wr(4'd6, 32'h01);
        check("fall_irq_enabled", {31'b0, irq}, 32'h1);

        // ---------------- pins high through reset release, then mid-operation reset ----------------
        ext_drv = 8'hFF;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        wr(4'd7, 32'hFF);
        repeat (5) tick();
        rd_chk("rel_stat", 4'd9, 32'h00);
        check("rel_irq", {31'b0, irq}, 32'h0);
        wr(4'd8, 32'hFF);
        wr(4'd6, 32'hFF);
        ext_drv = 8'h00;
        repeat (5) tick();
        rd_chk("pre_rst_stat", 4'd9, 32'hFF);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        rst = 1'b1; we = 1'b1; addr = 4'd0; wdata = 32'hFF;   // write during reset is ignored
        tick();
        we = 1'b0;
        check("rst_irq_same_edge", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        for (int a = 0; a < 10; a++) begin
            if (a != 2) rd_chk($sformatf("rst_reg%0d", a), a[3:0], 32'h0);
        end

        // ---------------- randomised run against reference model ----------------
        ext_en = 8'hFF; ext_drv = '0;
        rst = 1'b1;
        tick();                       // model edge 0
        rst = 1'b0;
        n_edge = 0; last_rst = 0;
        m_dir = '0; m_out = '0; m_en = '0; m_rise = '0; m_fall = '0; m_stat = '0;
        samp[0] = '0; hr[0] = '0; hf[0] = '0;

        for (int c = 0; c < 1500; c++) begin
            logic         r_rst, r_we;
            logic [3:0]   r_addr;
            logic [31:0]  r_wd;
            logic [W-1:0] pv, setv, clr, wv, in_new, in_old;
            int           a;

            r_rst = ($urandom_range(0, 79) == 0);
            r_we  = ($urandom_range(0, 2) != 0);
            a = $urandom_range(0, 19);
            if (a > 15) a = 9;
            r_addr = a[3:0];
            r_wd   = $urandom;
            if ($urandom_range(0, 2) == 0) ext_drv = $urandom;
            ext_en = ~m_dir;
            rst = r_rst; we = r_we; addr = r_addr; wdata = r_wd;
            #1;
            pv = (m_dir & m_out) | (~m_dir & ext_drv);
            check("rnd_pins", {24'b0, pins}, {24'b0, pv});
            check($sformatf("rnd_rd%0d", r_addr), rdata, model_read(r_addr));
            check("rnd_irq", {31'b0, irq}, {31'b0, |(m_stat & m_en)});

            @(posedge clk);
            n_edge++;
            samp[n_edge] = pv;
            if (r_rst) begin
                last_rst = n_edge;
                m_dir = '0; m_out = '0; m_en = '0; m_rise = '0; m_fall = '0; m_stat = '0;
            end else begin
                // A pin transition between captures n-S-2 and n-S-1 lands in IRQ_STAT
                // at edge n, using the edge masks that were in force after edge n-2.
                setv = '0;
                if (n_edge >= 2) begin
                    in_new = smp(n_edge - S - 1);
                    in_old = smp(n_edge - S - 2);
                    setv = (in_new & ~in_old & hr[n_edge-2]) | (~in_new & in_old & hf[n_edge-2]);
                end
                wv  = r_wd[W-1:0];
                clr = '0;
                if (r_we) begin
                    case (r_addr)
                        4'd0: m_dir  = wv;
                        4'd1: m_out  = wv;
                        4'd3: m_out  = m_out | wv;
                        4'd4: m_out  = m_out & ~wv;
                        4'd5: m_out  = m_out ^ wv;
                        4'd6: m_en   = wv;
                        4'd7: m_rise = wv;
                        4'd8: m_fall = wv;
                        4'd9: clr    = wv;
                        default: ;
                    endcase
                end
                m_stat = (m_stat & ~clr) | setv;
            end
            hr[n_edge] = m_rise;
            hf[n_edge] = m_fall;
            #1;
            rst = 1'b0; we = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 Parameter WIDTH, default 32, number of GPIO pins (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 addr  input  4  word register index.
REQ-006 we  input  1  write strobe, one write per asserted cycle.
REQ-007 wdata  input  32  write data; bits [31:WIDTH] ignored.
REQ-008 rdata  output  32  combinational read data for addr; bits [31:WIDTH] read 0.
REQ-009 gpio_pins  inout  WIDTH  bidirectional pins.
REQ-010 irq  output  1  level interrupt request.

Function
REQ-011 Register map SHALL be: 0 DIR rw, 1 OUT rw, 2 IN ro, 3 OUT_SET wo, 4 OUT_CLR wo, 5 OUT_TGL wo, 6 IRQ_EN rw, 7 IRQ_RISE rw, 8 IRQ_FALL rw, 9 IRQ_STAT rw1c; 10-15 read 0, writes ignored.
REQ-012 Pin i SHALL be driven with OUT[i] when DIR[i]=1, else high-impedance.
REQ-013 Each pin SHALL pass through a SYNC_STAGES-deep flop chain; IN SHALL equal the last stage.
REQ-014 A pin change sampled at edge k SHALL be visible in IN after edge k+SYNC_STAGES-1.
REQ-015 Writes to OUT_SET, OUT_CLR, OUT_TGL SHALL update OUT as OUT|wdata, OUT&~wdata, OUT^wdata at the next edge; these addresses read 0.
REQ-016 A register PREV SHALL hold IN delayed one cycle; rise[i]=IN[i]&~PREV[i], fall[i]=~IN[i]&PREV[i].
REQ-017 IRQ_STAT[i] SHALL set at the next edge when (rise[i]&IRQ_RISE[i]) | (fall[i]&IRQ_FALL[i]).
REQ-018 IRQ_STAT bits are captured regardless of IRQ_EN; IRQ_EN gates only irq.
REQ-019 Write to IRQ_STAT SHALL clear bits where wdata=1; bits with wdata=0 unchanged.
REQ-020 Simultaneous new edge and W1C on the same bit: set SHALL win (bit reads 1 afterwards).
REQ-021 irq SHALL equal OR-reduce(IRQ_STAT & IRQ_EN), combinational from registers, no extra latency.
REQ-022 Edge on a pin configured as output (DIR=1) SHALL be detected identically (loopback visible).
REQ-023 Edge-to-IRQ_STAT latency SHALL be SYNC_STAGES+1 edges from the sampling edge; irq same cycle as IRQ_STAT.
REQ-024 IRQ_RISE=IRQ_FALL=1 SHALL capture both edges; both 0 SHALL capture none.

Reset
REQ-025 While rst=1 at a rising edge: DIR, OUT, IRQ_EN, IRQ_RISE, IRQ_FALL, IRQ_STAT, all sync stages and PREV SHALL become 0; writes during reset ignored.
REQ-026 After reset, all pins SHALL be high-impedance, irq=0, rdata for addr 0 = 0.
REQ-027 Pins high at reset release SHALL produce a sync-chain 0->1 transition but SHALL NOT set IRQ_STAT because IRQ_RISE=0.
REQ-028 Reset asserted mid-operation SHALL clear pending IRQ_STAT and deassert irq on the same edge.

Verification
REQ-029 WIDTH=8: write DIR=0xFF, OUT=0xA5 -> gpio_pins=0xA5; OUT_SET 0x0A -> 0xAF; OUT_CLR 0x81 -> 0x2E; OUT_TGL 0xFF -> 0xD1; read addr 3 -> 0.
REQ-030 DIR=0, external pin 3 driven 0->1 at edge k, SYNC_STAGES=2 -> IN[3]=1 readable after edge k+1; with IRQ_RISE=0x08, IRQ_EN=0x08 -> IRQ_STAT=0x08 and irq=1 after edge k+3.
REQ-031 Pending IRQ_STAT=0x08, write IRQ_STAT=0x08 -> reads 0x00, irq=0; same-cycle new rise on pin 3 -> reads 0x08, irq=1.
REQ-032 IRQ_FALL=0x01, IRQ_EN=0: pin 0 falls -> IRQ_STAT=0x01, irq=0; then write IRQ_EN=0x01 -> irq=1 next cycle.
REQ-033 Pins held 0xFF through reset release, then IRQ_RISE=0xFF -> IRQ_STAT stays 0; assert rst with IRQ_STAT nonzero -> all registers 0, irq=0.
REQ-034 Write wdata=0xFFFF_FFFF to DIR with WIDTH=8 -> read DIR=0x0000_00FF; read addr 12 -> 0.
